aqe_prog_loader: RTL and testbench

Boot-time program loader that feeds the shared system SRAM's program-write port (`prog_wen` / `prog_waddr` / `prog_wdata`). It accepts a length-prefixed byte stream from the host-side link (UART or JTAG bridge), packs each 16 bytes into one 128-bit word, and issues one single-cycle write per word. It holds the core in reset (`cpu_hold`) until the image is fully written, so the SRAM's AXI side sees no traffic while programming.

---
 rtl/aqe_prog_loader.sv | 165 ++++++++++++++++
 tb/tb_aqe_prog_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aqe_prog_loader.sv
// aqe_prog_loader
// Boot-time program loader. Consumes a length-prefixed byte stream
// (2-byte little-endian word count, then 16 bytes per word), packs each
// 16 bytes little-endian into a 128-bit word and issues one single-cycle
// write per word on the SRAM program port. Holds the core in reset until
// the image is fully written.
//
// Ports:
//   pll_core_cpuclk, pad_cpu_rst     clock / async active-high reset
//   start                            begin a load (IDLE, DONE, ERR only)
//   byte_valid, byte_data, byte_ready  byte stream handshake
//   prog_wen, prog_waddr, prog_wdata   SRAM program write port
//   load_busy, load_done, load_err     status
//   cpu_hold                           core reset hold, active-high
//   words_loaded                       words written in current load
module aqe_prog_loader #(
  parameter int ADDR_WIDTH = 20,
  parameter int WORD_COUNT = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  prog_wen,
  output logic [ADDR_WIDTH-1:0] prog_waddr,
  output logic [127:0]          prog_wdata,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic                  cpu_hold,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] WC = 17'(WORD_COUNT);

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [127:0]            buf_q, buf_d;
  logic [127:0]            wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [15:0]             words_q, words_d;

  logic        hs;
  logic [15:0] hdr_len;

  assign hs      = byte_valid && byte_ready;
  // Full length as it stands on the HDR1 handshake.
  assign hdr_len = {byte_data, len_q[7:0]};

  // State register and datapath flops
  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      words_q <= words_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR0;
      S_HDR0:  if (hs) state_d = S_HDR1;
      S_HDR1: begin
        if (hs) begin
          if (hdr_len == 16'd0)               state_d = S_DONE;
          else if ({1'b0, hdr_len} > WC)      state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA:  if (hs && cnt_q == 4'd15) state_d = S_WRITE;
      S_WRITE: state_d = (words_q + 16'd1 == len_q) ? S_DONE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    words_d = words_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          cnt_d   = '0;
          words_d = '0;
        end
      end
      S_HDR0: if (hs) len_d[7:0]  = byte_data;
      S_HDR1: if (hs) len_d[15:8] = byte_data;
      S_DATA: begin
        if (hs) begin
          buf_d[{cnt_q, 3'b000} +: 8] = byte_data;
          cnt_d = cnt_q + 4'd1;
          // Latch the completed word and its address on the way into WRITE
          // so the program port only changes when a write is issued.
          if (cnt_q == 4'd15) begin
            wdata_d = buf_d;
            waddr_d = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_q);
          end
        end
      end
      S_WRITE: words_d = words_q + 16'd1;
      default: ;
    endcase
  end

  // Output decode (from registered state only)
  always_comb begin
    byte_ready = 1'b0;
    prog_wen   = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    cpu_hold   = 1'b1;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: begin
        byte_ready = 1'b1;
        load_busy  = 1'b1;
      end
      S_WRITE: begin
        prog_wen  = 1'b1;
        load_busy = 1'b1;
      end
      S_DONE: begin
        load_done = 1'b1;
        cpu_hold  = 1'b0;
      end
      S_ERR: begin
        load_err   = 1'b1;
        byte_ready = 1'b1;
      end
      default: ;
    endcase
  end

  assign prog_waddr   = waddr_q;
  assign prog_wdata   = wdata_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_aqe_prog_loader.sv
module tb_aqe_prog_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         prog_wen;
  logic [19:0]  prog_waddr;
  logic [127:0] prog_wdata;
  logic         load_busy, load_done, load_err, cpu_hold;
  logic [15:0]  words_loaded;

  int total = 0;
  int bad   = 0;

  logic [19:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];

  aqe_prog_loader dut (
    .pll_core_cpuclk(clk), .pad_cpu_rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .prog_wen(prog_wen), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .cpu_hold(cpu_hold), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write capture; byte_ready must be low in every write cycle.
  always @(negedge clk) begin
    if (prog_wen === 1'b1) begin
      wr_addr_q.push_back(prog_waddr);
      wr_data_q.push_back(prog_wdata);
      chk("ready_low_in_write", {127'd0, byte_ready}, 128'd0);
    end
  end

  function automatic logic [7:0] pat(input int seed, input int w, input int i);
    return 8'((w * 16 + i + seed) & 8'hff);
  endfunction

  function automatic logic [127:0] pat_word(input int seed, input int w);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = pat(seed, w, i);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      total++; bad++;
      $display("FAIL byte_timeout: byte_ready stuck at %b, required 1", byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    chk("start_busy",  {127'd0, load_busy},  128'd1);
    chk("start_ready", {127'd0, byte_ready}, 128'd1);
    chk("start_err",   {127'd0, load_err},   128'd0);
    chk("start_done",  {127'd0, load_done},  128'd0);
    chk("start_hold",  {127'd0, cpu_hold},   128'd1);
    chk("start_words", {112'd0, words_loaded}, 128'd0);
  endtask

  task automatic check_writes(input int seed, input int n);
    chk("write_count", 128'(wr_addr_q.size()), 128'(n));
    for (int w = 0; w < n && w < wr_addr_q.size(); w++) begin
      chk("write_addr", {108'd0, wr_addr_q[w]}, 128'(w));
      chk("write_data", wr_data_q[w], pat_word(seed, w));
    end
  endtask

  typedef struct {
    logic [7:0] lo, hi;
    int  nwords;     // data words sent
    int  drain;      // extra bytes sent after header (ERR case)
    int  maxgap;
    logic exp_done, exp_err;
    int  exp_words;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{8'h01, 8'h00, 1,    0, 0, 1'b1, 1'b0, 1};
    vecs[1] = '{8'h03, 8'h00, 3,    0, 3, 1'b1, 1'b0, 3};
    vecs[2] = '{8'h00, 8'h00, 0,    0, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{8'h01, 8'h04, 0,    5, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{8'h00, 8'h04, 1024, 0, 0, 1'b1, 1'b0, 1024};

    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", {127'd0, byte_ready}, 128'd0);
    chk("rst_wen",   {127'd0, prog_wen},   128'd0);
    chk("rst_addr",  {108'd0, prog_waddr}, 128'd0);
    chk("rst_data",  prog_wdata,           128'd0);
    chk("rst_busy",  {127'd0, load_busy},  128'd0);
    chk("rst_done",  {127'd0, load_done},  128'd0);
    chk("rst_err",   {127'd0, load_err},   128'd0);
    chk("rst_hold",  {127'd0, cpu_hold},   128'd1);
    chk("rst_words", {112'd0, words_loaded}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", {127'd0, byte_ready}, 128'd0);

    for (int v = 0; v < 5; v++) begin
      int seed;
      seed = v * 37;
      do_start();
      send_byte(vecs[v].lo, 0);
      send_byte(vecs[v].hi, 0);
      if (vecs[v].nwords == 0) begin
        // Header decision takes effect the very next cycle.
        chk("hdr_done", {127'd0, load_done}, {127'd0, vecs[v].exp_done});
        chk("hdr_err",  {127'd0, load_err},  {127'd0, vecs[v].exp_err});
        chk("hdr_hold", {127'd0, cpu_hold},  {127'd0, vecs[v].exp_err});
      end
      for (int d = 0; d < vecs[v].drain; d++) send_byte(8'hA5, 0);
      for (int w = 0; w < vecs[v].nwords; w++)
        for (int i = 0; i < 16; i++)
          send_byte(pat(seed, w, i),
                    vecs[v].maxgap == 0 ? 0 : $urandom_range(vecs[v].maxgap, 0));
      byte_valid = 1'b0;
      if (vecs[v].nwords > 0) begin
        chk("last_wen", {127'd0, prog_wen}, 128'd1);
        @(negedge clk);
      end
      chk("end_done",  {127'd0, load_done}, {127'd0, vecs[v].exp_done});
      chk("end_err",   {127'd0, load_err},  {127'd0, vecs[v].exp_err});
      chk("end_hold",  {127'd0, cpu_hold},  {127'd0, !vecs[v].exp_done});
      chk("end_busy",  {127'd0, load_busy}, 128'd0);
      chk("end_words", {112'd0, words_loaded}, 128'(vecs[v].exp_words));
      check_writes(seed, vecs[v].exp_words);
    end

    // start pulsed during DATA is ignored
    do_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(pat(5, 0, i), 0);
    for (int i = 0; i < 16; i++) begin
      if (i == 6) start = 1'b1;
      send_byte(pat(5, 1, i), 0);
      start = 1'b0;
    end
    byte_valid = 1'b0;
    @(negedge clk);
    chk("sd_done",  {127'd0, load_done}, 128'd1);
    chk("sd_words", {112'd0, words_loaded}, 128'd2);
    check_writes(5, 2);

    // reset after byte 7 of word 1 of a 4-word load
    do_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 16; i++) send_byte(pat(9, 0, i), 0);
    for (int i = 0; i < 8; i++) send_byte(pat(9, 1, i), 0);
    chk("pre_rst_busy", {127'd0, load_busy}, 128'd1);
    rst = 1'b1;
    #1;
    chk("mr_ready", {127'd0, byte_ready}, 128'd0);
    chk("mr_wen",   {127'd0, prog_wen},   128'd0);
    chk("mr_addr",  {108'd0, prog_waddr}, 128'd0);
    chk("mr_data",  prog_wdata,           128'd0);
    chk("mr_busy",  {127'd0, load_busy},  128'd0);
    chk("mr_done",  {127'd0, load_done},  128'd0);
    chk("mr_err",   {127'd0, load_err},   128'd0);
    chk("mr_hold",  {127'd0, cpu_hold},   128'd1);
    chk("mr_words", {112'd0, words_loaded}, 128'd0);
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_writes(9, 1);
    chk("post_rst_busy", {127'd0, load_busy}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
